sum_seq_ctrl: RTL
=================

SUM_SEQ_CTRL -- requirements
Module: sum_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, width of memory address and element count.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to sum a block; sampled only in IDLE.
REQ-005 base  input  ADDR_W  first memory address; captured when start is accepted.
REQ-006 len  input  ADDR_W  element count; captured when start is accepted; 0 is legal.
REQ-007 mem_addr  output  ADDR_W  read address driven to the synchronous memory.
REQ-008 mem_rd  output  1  memory read strobe; data is valid one cycle later.
REQ-009 clr_acc  output  1  synchronous clear to the accumulator register and the datapath count register.
REQ-010 ld_acc  output  1  load enable to the accumulator register (acc <= acc + mem_data).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse marking completion.
REQ-013 abort  input  1  cancel request; present only when SUM_SEQ_ABORT_EN is defined.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, CLEAR, READ, ACC, DONE; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE: start=1 -> CLEAR and capture base/len into internal addr and remaining-count registers; otherwise stay in IDLE.
REQ-016 CLEAR: clr_acc=1 for exactly one cycle; remaining=0 -> DONE, else -> READ.
REQ-017 READ: mem_rd=1, mem_addr=current addr; next state ACC.
REQ-018 ACC: ld_acc=1; addr increments by 1 modulo 2^ADDR_W; remaining decrements by 1; remaining==1 on entry -> DONE, else -> READ.
REQ-019 DONE: done=1 for one cycle; next state IDLE.
REQ-020 Latency SHALL be 2 + 2*len cycles from start-accept edge to the done-pulse cycle inclusive of CLEAR and DONE (len=0 -> 2 cycles).
REQ-021 mem_rd and ld_acc SHALL never be high in the same cycle; each element SHALL produce exactly one mem_rd followed next cycle by exactly one ld_acc.
REQ-022 start while busy SHALL be ignored; base/len changes while busy SHALL have no effect.
REQ-023 Address wrap: base+k beyond 2^ADDR_W-1 SHALL wrap to 0 without error.
REQ-024 mem_addr SHALL hold its last value outside READ; mem_rd, ld_acc, clr_acc, done SHALL be 0 outside their states.

Reset
REQ-025 rst=1 SHALL force IDLE, mem_addr=0, internal count=0, and mem_rd=ld_acc=clr_acc=done=busy=0 on the next edge, from any state.
REQ-026 Reset SHALL take priority over start and abort in the same cycle; a cycle after reset release start SHALL be accepted normally.

Configuration
REQ-027 Macro SUM_SEQ_ABORT_EN defined: abort port exists; abort=1 in CLEAR, READ or ACC -> IDLE next edge, no done pulse, no ld_acc in that edge's following cycle; abort in IDLE or DONE ignored (DONE still pulses).
REQ-028 Macro SUM_SEQ_ABORT_EN undefined: abort port and logic absent; every accepted start completes with done.

Verification
REQ-029 base=0x10, len=3, start 1 cycle -> clr_acc once, mem_addr 0x10,0x11,0x12 each with mem_rd, ld_acc following each, done 8 cycles after accept.
REQ-030 len=0, start -> CLEAR then DONE, done at cycle 2, zero mem_rd and zero ld_acc.
REQ-031 base=0xFE, len=4 -> mem_addr sequence 0xFE,0xFF,0x00,0x01; 4 ld_acc pulses.
REQ-032 start held high continuously with len=2 -> second run begins only after IDLE; start pulses mid-run ignored; busy low exactly one cycle between runs.
REQ-033 rst asserted during ACC of a len=5 run -> next cycle all outputs 0, state IDLE; no done.
REQ-034 With SUM_SEQ_ABORT_EN: abort in second READ of len=4 run -> IDLE next cycle, busy=0, no done, total 1 ld_acc observed.

Source files
------------

// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: sequencer that sums a block of memory through an external
// accumulator datapath. It clears the accumulator, then for each element it
// issues one memory read and, one cycle later, one accumulator load, and it
// finishes with a one-cycle done pulse.
// Optional feature: define SUM_SEQ_ABORT_EN to add the abort input, which
// cancels a run in CLEAR/READ/ACC without a done pulse.
module sum_seq_ctrl #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] len,
`ifdef SUM_SEQ_ABORT_EN
   input  logic              abort,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              clr_acc,
   output logic              ld_acc,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_READ,
      S_ACC,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] remain_q, remain_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              clr_acc_q, clr_acc_d;
   logic              ld_acc_q, ld_acc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Next state, address/count bookkeeping, and outputs decoded from the next
   // state so every output comes straight from a flop.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_CLEAR;
               addr_d   = base;
               remain_d = len;
            end
         end
         S_CLEAR: begin
            state_d = (remain_q == '0) ? S_DONE : S_READ;
         end
         S_READ: begin
            state_d = S_ACC;
         end
         S_ACC: begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - ADDR_W'(1);
            state_d  = (remain_q == ADDR_W'(1)) ? S_DONE : S_READ;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef SUM_SEQ_ABORT_EN
      if (abort && (state_q == S_CLEAR || state_q == S_READ || state_q == S_ACC)) begin
         state_d = S_IDLE;
      end
`endif

      mem_rd_d   = (state_d == S_READ);
      ld_acc_d   = (state_d == S_ACC);
      clr_acc_d  = (state_d == S_CLEAR);
      done_d     = (state_d == S_DONE);
      busy_d     = (state_d != S_IDLE);
      // Address register is loaded only on entry to READ and otherwise holds.
      mem_addr_d = (state_d == S_READ) ? addr_d : mem_addr_q;
   end

   // State and registered outputs; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         clr_acc_q  <= 1'b0;
         ld_acc_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         clr_acc_q  <= clr_acc_d;
         ld_acc_q   <= ld_acc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign clr_acc  = clr_acc_q;
   assign ld_acc   = ld_acc_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
